instr_encoder: RTL and testbench

RV32I instruction encoder: the inverse of the frontend decoder. Accepts an operation in the shared `DCODED_*` encoding plus register indices and a 32-bit immediate, and emits the packed 32-bit instruction word through a registered valid/ready output. Expands the `li` pseudo-op into LUI+ADDI, and flags immediates that do not fit the instruction format. Used by the self-test instruction generator and the boot-stub builder to feed instruction memory.

---
 rtl/instr_encoder.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder.
// Turns a DCODED_* operation plus register indices and an immediate into a
// packed 32-bit instruction word. The word is held in a registered
// valid/ready output slot. The `li` pseudo-op expands into LUI and/or ADDI.
// err_o flags an immediate that does not fit the instruction format; the
// word is still emitted, with its fields truncated.

package dcode_pkg;

    localparam int DCODE_WIDTH = 6;

    localparam logic [DCODE_WIDTH-1:0] DCODED_ILLEGAL = 6'd0;
    localparam logic [DCODE_WIDTH-1:0] DCODED_LUI     = 6'd1;
    localparam logic [DCODE_WIDTH-1:0] DCODED_AUIPC   = 6'd2;
    localparam logic [DCODE_WIDTH-1:0] DCODED_JAL     = 6'd3;
    localparam logic [DCODE_WIDTH-1:0] DCODED_JALR    = 6'd4;
    localparam logic [DCODE_WIDTH-1:0] DCODED_BEQ     = 6'd5;
    localparam logic [DCODE_WIDTH-1:0] DCODED_BNE     = 6'd6;
    localparam logic [DCODE_WIDTH-1:0] DCODED_BLT     = 6'd7;
    localparam logic [DCODE_WIDTH-1:0] DCODED_BGE     = 6'd8;
    localparam logic [DCODE_WIDTH-1:0] DCODED_BLTU    = 6'd9;
    localparam logic [DCODE_WIDTH-1:0] DCODED_BGEU    = 6'd10;
    localparam logic [DCODE_WIDTH-1:0] DCODED_LB      = 6'd11;
    localparam logic [DCODE_WIDTH-1:0] DCODED_LH      = 6'd12;
    localparam logic [DCODE_WIDTH-1:0] DCODED_LW      = 6'd13;
    localparam logic [DCODE_WIDTH-1:0] DCODED_LBU     = 6'd14;
    localparam logic [DCODE_WIDTH-1:0] DCODED_LHU     = 6'd15;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SB      = 6'd16;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SH      = 6'd17;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SW      = 6'd18;
    localparam logic [DCODE_WIDTH-1:0] DCODED_ADDI    = 6'd19;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SLTI    = 6'd20;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SLTIU   = 6'd21;
    localparam logic [DCODE_WIDTH-1:0] DCODED_XORI    = 6'd22;
    localparam logic [DCODE_WIDTH-1:0] DCODED_ORI     = 6'd23;
    localparam logic [DCODE_WIDTH-1:0] DCODED_ANDI    = 6'd24;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SLLI    = 6'd25;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SRLI    = 6'd26;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SRAI    = 6'd27;
    localparam logic [DCODE_WIDTH-1:0] DCODED_ADD     = 6'd28;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SUB     = 6'd29;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SLL     = 6'd30;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SLT     = 6'd31;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SLTU    = 6'd32;
    localparam logic [DCODE_WIDTH-1:0] DCODED_XOR     = 6'd33;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SRL     = 6'd34;
    localparam logic [DCODE_WIDTH-1:0] DCODED_SRA     = 6'd35;
    localparam logic [DCODE_WIDTH-1:0] DCODED_OR      = 6'd36;
    localparam logic [DCODE_WIDTH-1:0] DCODED_AND     = 6'd37;

endpackage

module instr_encoder
    import dcode_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DCODE_WIDTH-1:0] op_i,
    input  logic                   li_i,
    input  logic [4:0]             rd_i,
    input  logic [4:0]             rs1_i,
    input  logic [4:0]             rs2_i,
    input  logic [31:0]            imm_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            instr_o,
    output logic                   err_o
);

    // Major opcodes
    localparam logic [6:0] OPC_COMP    = 7'h33;
    localparam logic [6:0] OPC_COMPIMM = 7'h13;
    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_STORE   = 7'h23;
    localparam logic [6:0] OPC_BRANCH  = 7'h63;
    localparam logic [6:0] OPC_JALR    = 7'h67;
    localparam logic [6:0] OPC_JAL     = 7'h6F;
    localparam logic [6:0] OPC_AUIPC   = 7'h17;
    localparam logic [6:0] OPC_LUI     = 7'h37;

    // funct7 for SUB/SRA/SRAI
    localparam logic [6:0]  F7_ALT   = 7'h20;
    localparam logic [6:0]  F7_BASE  = 7'h00;
    // ADDI x0,x0,0: emitted after reset and for unknown operations
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_BAD
    } fmt_t;

    typedef enum logic {
        ST_IDLE,
        ST_LI_LO
    } state_t;

    // Decoded op properties
    fmt_t        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    // Immediate range checks
    logic        fits_i;
    logic        fits_sh;
    logic        fits_b;
    logic        fits_j;
    logic        fits_u;

    // Encoded word for a non-li request
    logic [31:0] enc_instr;
    logic        enc_err;

    // li expansion
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic [31:0] li_first;
    logic        li_two_words;
    logic [31:0] li_second;

    // Registered state
    state_t      state_reg;
    logic        out_valid_reg;
    logic [31:0] instr_reg;
    logic        err_reg;
    logic [4:0]  li_rd_reg;
    logic [11:0] li_lo_reg;

    // Handshake
    logic        slot_free;
    logic        accept;

    // A value fits a signed field when every bit above the field's sign bit
    // matches it, i.e. the upper slice is all zeros or all ones.
    assign fits_i  = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits_sh = ~(|imm_i[31:5]);
    assign fits_b  = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];
    assign fits_j  = ((&imm_i[31:20]) | ~(|imm_i[31:20])) & ~imm_i[0];
    assign fits_u  = ~(|imm_i[11:0]);

    // Map the operation code to its format, opcode and function fields
    always_comb begin
        fmt    = FMT_BAD;
        opcode = OPC_COMPIMM;
        funct3 = 3'b000;
        funct7 = F7_BASE;
        case (op_i)
            DCODED_LUI:   begin fmt = FMT_U; opcode = OPC_LUI;   end
            DCODED_AUIPC: begin fmt = FMT_U; opcode = OPC_AUIPC; end
            DCODED_JAL:   begin fmt = FMT_J; opcode = OPC_JAL;   end
            DCODED_JALR:  begin fmt = FMT_I; opcode = OPC_JALR;  funct3 = 3'b000; end

            DCODED_BEQ:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'b000; end
            DCODED_BNE:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'b001; end
            DCODED_BLT:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'b100; end
            DCODED_BGE:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'b101; end
            DCODED_BLTU:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'b110; end
            DCODED_BGEU:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'b111; end

            DCODED_LB:    begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = 3'b000; end
            DCODED_LH:    begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = 3'b001; end
            DCODED_LW:    begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = 3'b010; end
            DCODED_LBU:   begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = 3'b100; end
            DCODED_LHU:   begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = 3'b101; end

            DCODED_SB:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = 3'b000; end
            DCODED_SH:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = 3'b001; end
            DCODED_SW:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = 3'b010; end

            DCODED_ADDI:  begin fmt = FMT_I; opcode = OPC_COMPIMM; funct3 = 3'b000; end
            DCODED_SLTI:  begin fmt = FMT_I; opcode = OPC_COMPIMM; funct3 = 3'b010; end
            DCODED_SLTIU: begin fmt = FMT_I; opcode = OPC_COMPIMM; funct3 = 3'b011; end
            DCODED_XORI:  begin fmt = FMT_I; opcode = OPC_COMPIMM; funct3 = 3'b100; end
            DCODED_ORI:   begin fmt = FMT_I; opcode = OPC_COMPIMM; funct3 = 3'b110; end
            DCODED_ANDI:  begin fmt = FMT_I; opcode = OPC_COMPIMM; funct3 = 3'b111; end

            DCODED_SLLI:  begin fmt = FMT_SH; opcode = OPC_COMPIMM; funct3 = 3'b001; end
            DCODED_SRLI:  begin fmt = FMT_SH; opcode = OPC_COMPIMM; funct3 = 3'b101; end
            DCODED_SRAI:  begin fmt = FMT_SH; opcode = OPC_COMPIMM; funct3 = 3'b101; funct7 = F7_ALT; end

            DCODED_ADD:   begin fmt = FMT_R; opcode = OPC_COMP; funct3 = 3'b000; end
            DCODED_SUB:   begin fmt = FMT_R; opcode = OPC_COMP; funct3 = 3'b000; funct7 = F7_ALT; end
            DCODED_SLL:   begin fmt = FMT_R; opcode = OPC_COMP; funct3 = 3'b001; end
            DCODED_SLT:   begin fmt = FMT_R; opcode = OPC_COMP; funct3 = 3'b010; end
            DCODED_SLTU:  begin fmt = FMT_R; opcode = OPC_COMP; funct3 = 3'b011; end
            DCODED_XOR:   begin fmt = FMT_R; opcode = OPC_COMP; funct3 = 3'b100; end
            DCODED_SRL:   begin fmt = FMT_R; opcode = OPC_COMP; funct3 = 3'b101; end
            DCODED_SRA:   begin fmt = FMT_R; opcode = OPC_COMP; funct3 = 3'b101; funct7 = F7_ALT; end
            DCODED_OR:    begin fmt = FMT_R; opcode = OPC_COMP; funct3 = 3'b110; end
            DCODED_AND:   begin fmt = FMT_R; opcode = OPC_COMP; funct3 = 3'b111; end
            default:      ;
        endcase
    end

    // Pack fields by format; registers a format does not use stay zero
    always_comb begin
        enc_instr = NOP_WORD;
        enc_err   = 1'b1;
        case (fmt)
            FMT_R: begin
                enc_instr = {funct7, rs2_i, rs1_i, funct3, rd_i, opcode};
                enc_err   = 1'b0;
            end
            FMT_I: begin
                enc_instr = {imm_i[11:0], rs1_i, funct3, rd_i, opcode};
                enc_err   = ~fits_i;
            end
            FMT_SH: begin
                enc_instr = {funct7, imm_i[4:0], rs1_i, funct3, rd_i, opcode};
                enc_err   = ~fits_sh;
            end
            FMT_S: begin
                enc_instr = {imm_i[11:5], rs2_i, rs1_i, funct3, imm_i[4:0], opcode};
                enc_err   = ~fits_i;
            end
            FMT_B: begin
                enc_instr = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3,
                             imm_i[4:1], imm_i[11], opcode};
                enc_err   = ~fits_b;
            end
            FMT_J: begin
                enc_instr = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                             rd_i, opcode};
                enc_err   = ~fits_j;
            end
            FMT_U: begin
                enc_instr = {imm_i[31:12], rd_i, opcode};
                enc_err   = ~fits_u;
            end
            default: ;
        endcase
    end

    // li: the upper part is rounded up when lo is negative so that the
    // sign-extended ADDI restores the exact value.
    assign li_hi        = imm_i[31:12] + {19'd0, imm_i[11]};
    assign li_lo        = imm_i[11:0];
    assign li_two_words = (li_hi != 20'd0) && (li_lo != 12'd0);
    assign li_first     = (li_hi == 20'd0)
                        ? {li_lo, 5'd0, 3'b000, rd_i, OPC_COMPIMM}
                        : {li_hi, rd_i, OPC_LUI};
    assign li_second    = {li_lo_reg, li_rd_reg, 3'b000, li_rd_reg, OPC_COMPIMM};

    assign slot_free  = ~out_valid_reg | out_ready_i;
    assign in_ready_o = (state_reg == ST_IDLE) & slot_free;
    assign accept     = in_valid_i & in_ready_o;

    // Output slot and li sequencing
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            instr_reg     <= NOP_WORD;
            err_reg       <= 1'b0;
            li_rd_reg     <= 5'd0;
            li_lo_reg     <= 12'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        out_valid_reg <= 1'b1;
                        if (li_i) begin
                            instr_reg <= li_first;
                            err_reg   <= 1'b0;
                            if (li_two_words) begin
                                li_rd_reg <= rd_i;
                                li_lo_reg <= li_lo;
                                state_reg <= ST_LI_LO;
                            end
                        end else begin
                            instr_reg <= enc_instr;
                            err_reg   <= enc_err;
                        end
                    end else if (out_valid_reg && out_ready_i) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                ST_LI_LO: begin
                    // The LUI word is always valid here, so the slot frees
                    // exactly when it is taken; the ADDI follows with no gap.
                    if (slot_free) begin
                        out_valid_reg <= 1'b1;
                        instr_reg     <= li_second;
                        err_reg       <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_reg;
    assign instr_o     = instr_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed cases followed by randomized traffic,
// checked against a table-driven reference encoder and a queue of words
// that the consumer is owed.
module tb_instr_encoder;
    import dcode_pkg::*;

    localparam int F_R = 0, F_I = 1, F_SH = 2, F_S = 3, F_B = 4, F_J = 5, F_U = 6, F_BAD = 7;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [DCODE_WIDTH-1:0] op = '0;
    logic                   li = 1'b0;
    logic [4:0]             rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0]            imm = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [31:0]            instr;
    logic                   err;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Words owed to the consumer, oldest first: {err, instr}
    logic [32:0] exp_q[$];

    // Directed requests may carry literal expected words instead of the model
    bit          use_lit = 1'b0;
    int          lit_n   = 0;
    logic [32:0] lit_w0, lit_w1;
    bit          last_acc = 1'b0;

    int          fmt_tab[64];
    logic [6:0]  opc_tab[64];
    logic [2:0]  f3_tab[64];
    logic [6:0]  f7_tab[64];

    logic [31:0] bnd[20] = '{32'hFFFFF7FF, 32'hFFFFF800, 32'd2047, 32'd2048, 32'd31,
                             32'd32, 32'hFFFFFFFF, 32'd0, 32'hFFFFF000, 32'hFFFFEFFE,
                             32'd4094, 32'd4095, 32'd4096, 32'h000FFFFE, 32'h00100000,
                             32'hFFF00000, 32'hFFEFFFFE, 32'h12345FFF, 32'h7FFFF800,
                             32'h00000800};

    instr_encoder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .li_i        (li),
        .rd_i        (rd),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .imm_i       (imm),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .instr_o     (instr),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic def(input logic [5:0] code, input int f, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [6:0] f7);
        fmt_tab[code] = f;
        opc_tab[code] = opc;
        f3_tab[code]  = f3;
        f7_tab[code]  = f7;
    endtask

    task automatic init_tables();
        for (int i = 0; i < 64; i++) def(6'(i), F_BAD, 7'h13, 3'd0, 7'd0);
        def(DCODED_LUI,   F_U,  7'h37, 3'd0, 7'd0);
        def(DCODED_AUIPC, F_U,  7'h17, 3'd0, 7'd0);
        def(DCODED_JAL,   F_J,  7'h6F, 3'd0, 7'd0);
        def(DCODED_JALR,  F_I,  7'h67, 3'd0, 7'd0);
        def(DCODED_BEQ,   F_B,  7'h63, 3'd0, 7'd0);
        def(DCODED_BNE,   F_B,  7'h63, 3'd1, 7'd0);
        def(DCODED_BLT,   F_B,  7'h63, 3'd4, 7'd0);
        def(DCODED_BGE,   F_B,  7'h63, 3'd5, 7'd0);
        def(DCODED_BLTU,  F_B,  7'h63, 3'd6, 7'd0);
        def(DCODED_BGEU,  F_B,  7'h63, 3'd7, 7'd0);
        def(DCODED_LB,    F_I,  7'h03, 3'd0, 7'd0);
        def(DCODED_LH,    F_I,  7'h03, 3'd1, 7'd0);
        def(DCODED_LW,    F_I,  7'h03, 3'd2, 7'd0);
        def(DCODED_LBU,   F_I,  7'h03, 3'd4, 7'd0);
        def(DCODED_LHU,   F_I,  7'h03, 3'd5, 7'd0);
        def(DCODED_SB,    F_S,  7'h23, 3'd0, 7'd0);
        def(DCODED_SH,    F_S,  7'h23, 3'd1, 7'd0);
        def(DCODED_SW,    F_S,  7'h23, 3'd2, 7'd0);
        def(DCODED_ADDI,  F_I,  7'h13, 3'd0, 7'd0);
        def(DCODED_SLTI,  F_I,  7'h13, 3'd2, 7'd0);
        def(DCODED_SLTIU, F_I,  7'h13, 3'd3, 7'd0);
        def(DCODED_XORI,  F_I,  7'h13, 3'd4, 7'd0);
        def(DCODED_ORI,   F_I,  7'h13, 3'd6, 7'd0);
        def(DCODED_ANDI,  F_I,  7'h13, 3'd7, 7'd0);
        def(DCODED_SLLI,  F_SH, 7'h13, 3'd1, 7'h00);
        def(DCODED_SRLI,  F_SH, 7'h13, 3'd5, 7'h00);
        def(DCODED_SRAI,  F_SH, 7'h13, 3'd5, 7'h20);
        def(DCODED_ADD,   F_R,  7'h33, 3'd0, 7'h00);
        def(DCODED_SUB,   F_R,  7'h33, 3'd0, 7'h20);
        def(DCODED_SLL,   F_R,  7'h33, 3'd1, 7'h00);
        def(DCODED_SLT,   F_R,  7'h33, 3'd2, 7'h00);
        def(DCODED_SLTU,  F_R,  7'h33, 3'd3, 7'h00);
        def(DCODED_XOR,   F_R,  7'h33, 3'd4, 7'h00);
        def(DCODED_SRL,   F_R,  7'h33, 3'd5, 7'h00);
        def(DCODED_SRA,   F_R,  7'h33, 3'd5, 7'h20);
        def(DCODED_OR,    F_R,  7'h33, 3'd6, 7'h00);
        def(DCODED_AND,   F_R,  7'h33, 3'd7, 7'h00);
    endtask

    // Reference encoder: field placement by shifts and masks, range limits as integers
    function automatic logic [32:0] ref_word(input logic [5:0] o, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [31:0] im);
        logic [31:0] w, opc, f3, f7, rdw, r1, r2;
        logic        e;
        int          s;
        s   = $signed(im);
        opc = 32'(opc_tab[o]);
        f3  = 32'(f3_tab[o]);
        f7  = 32'(f7_tab[o]);
        rdw = 32'(d);
        r1  = 32'(s1);
        r2  = 32'(s2);
        case (fmt_tab[o])
            F_R: begin
                w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rdw << 7) | opc;
                e = 1'b0;
            end
            F_I: begin
                w = ((im & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rdw << 7) | opc;
                e = (s < -2048) || (s > 2047);
            end
            F_SH: begin
                w = (f7 << 25) | ((im & 32'h1F) << 20) | (r1 << 15) | (f3 << 12) | (rdw << 7) | opc;
                e = (im > 32'd31);
            end
            F_S: begin
                w = (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                  | ((im & 32'h1F) << 7) | opc;
                e = (s < -2048) || (s > 2047);
            end
            F_B: begin
                w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
                  | (r1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
                  | (((im >> 11) & 32'h1) << 7) | opc;
                e = (s < -4096) || (s > 4094) || ((im & 32'h1) != 0);
            end
            F_J: begin
                w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                  | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                  | (rdw << 7) | opc;
                e = (s < -1048576) || (s > 1048574) || ((im & 32'h1) != 0);
            end
            F_U: begin
                w = (im & 32'hFFFFF000) | (rdw << 7) | opc;
                e = ((im & 32'hFFF) != 0);
            end
            default: begin
                w = 32'h00000013;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    // Push the word(s) the current request should produce
    task automatic push_expected();
        logic [31:0] hi, lo, rdw;
        if (use_lit) begin
            exp_q.push_back(lit_w0);
            if (lit_n == 2) exp_q.push_back(lit_w1);
        end else if (li) begin
            rdw = 32'(rd);
            hi  = ((imm >> 12) + ((imm >> 11) & 32'h1)) & 32'hFFFFF;
            lo  = imm & 32'hFFF;
            if (hi == 0) begin
                exp_q.push_back({1'b0, (lo << 20) | (rdw << 7) | 32'h13});
            end else begin
                exp_q.push_back({1'b0, (hi << 12) | (rdw << 7) | 32'h37});
                if (lo != 0) exp_q.push_back({1'b0, (lo << 20) | (rdw << 15) | (rdw << 7) | 32'h13});
            end
        end else begin
            exp_q.push_back(ref_word(op, rd, rs1, rs2, imm));
        end
    endtask

    // One clock: compare outputs, account for take/accept, advance to next negedge
    task automatic tick();
        bit          exp_ready;
        bit          took;
        logic [32:0] f;
        #1;
        exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        took = (exp_q.size() != 0) && out_ready;
        if (exp_q.size() != 0) begin
            f = exp_q[0];
            check("instr", instr, f[31:0]);
            check("err", 32'(err), 32'(f[32]));
        end
        last_acc = in_valid && exp_ready;
        if (took) begin
            n_txn++;
            $display("txn %0d: instr=%08h err=%0b", n_txn, instr, err);
            void'(exp_q.pop_front());
        end
        if (last_acc) push_expected();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic l, input logic [5:0] o, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                        input int n, input logic [32:0] w0, input logic [32:0] w1);
        li = l; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
        use_lit = 1'b1; lit_n = n; lit_w0 = w0; lit_w1 = w1;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        check("accept_timeout", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        use_lit  = 1'b0;
    endtask

    task automatic check_reset_state();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", instr, 32'h00000013);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_imm();
        int v;
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = $urandom;
            1: r = 32'($urandom_range(0, 40));
            2: r = bnd[$urandom_range(0, 19)];
            3: begin v = int'($urandom_range(0, 8191)) - 4096; r = 32'(v); end
            4: begin v = int'($urandom_range(0, 4194303)) - 2097152; r = 32'(v); end
            default: r = $urandom & 32'hFFFFF000;
        endcase
        return r;
    endfunction

    initial begin
        init_tables();

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        // ADD x3,x1,x2
        out_ready = 1'b1;
        send(1'b0, DCODED_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1, {1'b0, 32'h002081B3}, '0);
        // li x5,0x12345FFF -> LUI then ADDI on consecutive cycles
        send(1'b1, DCODED_ILLEGAL, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 2,
             {1'b0, 32'h123462B7}, {1'b0, 32'hFFF28293});
        // SW x2,8(x1)
        send(1'b0, DCODED_SW, 5'd0, 5'd1, 5'd2, 32'd8, 1, {1'b0, 32'h0020A423}, '0);
        // ADDI x1,x0,2048 overflows the 12-bit field
        send(1'b0, DCODED_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 1, {1'b1, 32'h80000093}, '0);
        repeat (2) tick();

        // Backpressure: ADD held three cycles while an SW waits, then back-to-back
        out_ready = 1'b0;
        send(1'b0, DCODED_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1, {1'b0, 32'h002081B3}, '0);
        op = DCODED_SW; li = 1'b0; rd = 5'd0; rs1 = 5'd1; rs2 = 5'd2; imm = 32'd8;
        use_lit = 1'b1; lit_n = 1; lit_w0 = {1'b0, 32'h0020A423};
        in_valid = 1'b1;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        use_lit  = 1'b0;
        repeat (2) tick();

        // Reset while the LUI is held and the ADDI is pending
        out_ready = 1'b0;
        send(1'b1, DCODED_ILLEGAL, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 2,
             {1'b0, 32'h123462B7}, {1'b0, 32'hFFF28293});
        tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check_reset_state();
        out_ready = 1'b1;
        repeat (3) tick();

        // Randomized traffic; an unaccepted request is held unchanged
        last_acc = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid = ($urandom_range(0, 9) < 7);
                li       = ($urandom_range(0, 5) == 0);
                op       = ($urandom_range(0, 19) == 0) ? 6'd63 : 6'($urandom_range(0, 40));
                rd       = 5'($urandom_range(0, 31));
                rs1      = 5'($urandom_range(0, 31));
                rs2      = 5'($urandom_range(0, 31));
                imm      = rand_imm();
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
